// File: rtl/sfr_slave_regfile.sv
// sfr_slave_regfile: target end of the SFR bus. Decodes sfraddr/sfr_page_sel
// against a paged register bank, completes each access after WAIT_STATES
// wait cycles with a one-cycle sfrack, and exports all registers flat.
// Optional build macro SFR_SLAVE_WP_EN: register 0 of the last page becomes
// a lock register; while its bit0 is set, writes to every other register
// are acknowledged but dropped.
module sfr_slave_regfile #(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    PAGE_NUM    = 2,
   parameter int                    REG_NUM     = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 8'h80,
   parameter int                    WAIT_STATES = 1,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   localparam int PAGE_W = (PAGE_NUM > 1) ? $clog2(PAGE_NUM) : 1,
   localparam int IDX_W  = (PAGE_NUM * REG_NUM > 1) ? $clog2(PAGE_NUM * REG_NUM) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [ADDR_WIDTH-1:0]              sfraddr,
   input  logic                               sfrwe,
   input  logic [DATA_WIDTH-1:0]              sfrdatao,
   input  logic                               sfroe,
   input  logic [PAGE_W-1:0]                  sfr_page_sel,
   output logic                               sfrack,
   output logic [DATA_WIDTH-1:0]              sfrdatai,
   output logic [PAGE_NUM*REG_NUM*DATA_WIDTH-1:0] reg_out,
   output logic                               wr_strobe,
   output logic [IDX_W-1:0]                   wr_index,
   output logic                               protocol_err
);

   localparam int NREGS = PAGE_NUM * REG_NUM;
   localparam int OFF_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

   // Widened by one bit so BASE_ADDR+REG_NUM past the top of the address
   // space still yields a correct upper bound.
   localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH + 1)'(REG_NUM);

   // Counter value at which the last wait cycle is reached.
   localparam logic [3:0] WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef SFR_SLAVE_WP_EN
   localparam logic [IDX_W-1:0] LOCK_IDX = IDX_W'((PAGE_NUM - 1) * REG_NUM);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [DATA_WIDTH-1:0] regs [NREGS];

   // Request decode
   logic [ADDR_WIDTH:0] addr_ext;
   logic                addr_hit;
   logic                page_ok;
   logic                req_hit;
   logic [OFF_W-1:0]    in_offset;
   logic [IDX_W-1:0]    in_index;

   // Captured request
   logic [IDX_W-1:0]      cap_index;
   logic [DATA_WIDTH-1:0] cap_data;
   logic                  cap_we;
   logic                  cap_oe;

   // Request as seen by the commit logic (live inputs when capture and ack coincide)
   logic [IDX_W-1:0]      acc_index;
   logic [DATA_WIDTH-1:0] acc_data;
   logic                  acc_we;
   logic                  acc_oe;
   logic                  write_ok;

   logic [3:0] wait_cnt;
   logic       capture;
   logic       enter_ack;

   assign addr_ext  = {1'b0, sfraddr};
   assign addr_hit  = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
   assign page_ok   = int'(sfr_page_sel) < PAGE_NUM;
   assign req_hit   = (sfrwe | sfroe) & addr_hit & page_ok;
   assign in_offset = OFF_W'(sfraddr - BASE_ADDR);
   assign in_index  = IDX_W'(int'(sfr_page_sel) * REG_NUM + int'(in_offset));

   assign acc_index = capture ? in_index : cap_index;
   assign acc_data  = capture ? sfrdatao : cap_data;
   assign acc_we    = capture ? sfrwe    : cap_we;
   assign acc_oe    = capture ? sfroe    : cap_oe;

`ifdef SFR_SLAVE_WP_EN
   assign write_ok = acc_we & ~acc_oe & (~regs[LOCK_IDX][0] | (acc_index == LOCK_IDX));
`else
   assign write_ok = acc_we & ~acc_oe;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state: capture in IDLE, count waits, single ACK, single GAP
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      enter_ack  = 1'b0;
      case (state)
         IDLE: begin
            if (req_hit) begin
               capture = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_next = ACK;
                  enter_ack  = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_next = ACK;
               enter_ack  = 1'b1;
            end
         end
         ACK:     state_next = GAP;
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Wait-state counter, cleared on capture and advanced while waiting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= 4'd0;
      end else if (capture) begin
         wait_cnt <= 4'd0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Request capture; later changes on the bus are ignored until the next IDLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_index <= '0;
         cap_data  <= '0;
         cap_we    <= 1'b0;
         cap_oe    <= 1'b0;
      end else if (capture) begin
         cap_index <= in_index;
         cap_data  <= sfrdatao;
         cap_we    <= sfrwe;
         cap_oe    <= sfroe;
      end
   end

   // Response pulses registered on entry to ACK so they are visible during ACK
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sfrack       <= 1'b0;
         wr_strobe    <= 1'b0;
         wr_index     <= '0;
         protocol_err <= 1'b0;
         sfrdatai     <= '0;
      end else begin
         sfrack       <= enter_ack;
         wr_strobe    <= enter_ack & write_ok;
         protocol_err <= capture & sfrwe & sfroe;
         if (enter_ack) begin
            if (acc_we & acc_oe) begin
               sfrdatai <= '0;
            end else if (acc_oe) begin
               sfrdatai <= regs[acc_index];
            end
            if (write_ok) begin
               wr_index <= acc_index;
            end
         end
      end
   end

   // Register bank: a write commits on entry to ACK, so reads issued later see it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= RESET_VALUE;
         end
      end else if (enter_ack && write_ok) begin
         regs[acc_index] <= acc_data;
      end
   end

   // Flat export, page-major with register 0 in the least significant bits
   genvar g;
   generate
      for (g = 0; g < NREGS; g++) begin : g_export
         assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
      end
   endgenerate

endmodule

// File: tb/tb_sfr_slave_regfile.sv
// tb_sfr_slave_regfile: scoreboard bench for sfr_slave_regfile with default
// parameters. Stimulus pushes expected responses; a negedge monitor checks
// every acknowledge against them.
module tb_sfr_slave_regfile;

   localparam int NPAGE = 2;
   localparam int NREG  = 16;
   localparam int WS    = 1;
   localparam int NTOT  = NPAGE * NREG;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [7:0]           sfraddr = '0;
   logic                 sfrwe = 1'b0;
   logic [7:0]           sfrdatao = '0;
   logic                 sfroe = 1'b0;
   logic [0:0]           sfr_page_sel = '0;
   logic                 sfrack;
   logic [7:0]           sfrdatai;
   logic [NTOT*8-1:0]    reg_out;
   logic                 wr_strobe;
   logic [4:0]           wr_index;
   logic                 protocol_err;

   sfr_slave_regfile dut (
      .clk          (clk),
      .rst          (rst),
      .sfraddr      (sfraddr),
      .sfrwe        (sfrwe),
      .sfrdatao     (sfrdatao),
      .sfroe        (sfroe),
      .sfr_page_sel (sfr_page_sel),
      .sfrack       (sfrack),
      .sfrdatai     (sfrdatai),
      .reg_out      (reg_out),
      .wr_strobe    (wr_strobe),
      .wr_index     (wr_index),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         ack_cyc;
      bit         chk_data;
      logic [7:0] data;
      bit         strobe;
      int         idx;
      logic [7:0] regval;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   perr_cyc = -1;
   logic [7:0] mdl [NTOT];

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [NTOT*8-1:0] model_flat();
      logic [NTOT*8-1:0] v;
      for (int i = 0; i < NTOT; i++) v[i*8 +: 8] = mdl[i];
      return v;
   endfunction

   task automatic check_regs(input string name);
      logic [NTOT*8-1:0] want;
      want = model_flat();
      n_checks++;
      if (reg_out !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, reg_out, want);
      end
   endtask

   function automatic bit model_locked();
`ifdef SFR_SLAVE_WP_EN
      return mdl[(NPAGE-1)*NREG][0];
`else
      return 1'b0;
`endif
   endfunction

   // One bus access from the master side; misses are held for 20 cycles
   task automatic access(input int a, input int pg, input bit we, input bit oe, input logic [7:0] d);
      bit   hit;
      bit   seen;
      int   idx;
      exp_t x;
      @(negedge clk);
      sfraddr      = 8'(a);
      sfr_page_sel = 1'(pg);
      sfrwe        = we;
      sfroe        = oe;
      sfrdatao     = d;
      hit = (a >= 8'h80) && (a < 8'h80 + NREG) && (pg < NPAGE) && (we || oe);
      if (hit) begin
         idx       = pg * NREG + (a - 8'h80);
         x.ack_cyc = cyc + 1 + WS;
         x.idx     = idx;
         if (we && oe) begin
            x.chk_data = 1'b1;
            x.data     = 8'h00;
            x.strobe   = 1'b0;
            perr_cyc   = cyc + 1;
         end else if (we) begin
            x.chk_data = 1'b0;
            x.data     = 8'h00;
            x.strobe   = !model_locked() || (idx == (NPAGE-1)*NREG);
            if (x.strobe) mdl[idx] = d;
         end else begin
            x.chk_data = 1'b1;
            x.data     = mdl[idx];
            x.strobe   = 1'b0;
         end
         x.regval = mdl[idx];
         exp_q.push_back(x);
         seen = 1'b0;
         for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (sfrack) seen = 1'b1;
         end
         sfrwe = 1'b0;
         sfroe = 1'b0;
         if (!seen) begin
            check("ack_timeout", 0, 1);
            void'(exp_q.pop_back());
         end
         @(negedge clk);
      end else begin
         repeat (20) @(negedge clk);
         sfrwe = 1'b0;
         sfroe = 1'b0;
         check_regs("miss_regs_unchanged");
      end
   endtask

   // Monitor: every acknowledge is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst) begin
         if (sfrack) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("ack_latency", cyc, e.ack_cyc);
               if (e.chk_data) check("sfrdatai", sfrdatai, e.data);
               check("wr_strobe", wr_strobe, e.strobe);
               if (e.strobe) check("wr_index", wr_index, e.idx);
               check("reg_after_ack", reg_out[e.idx*8 +: 8], e.regval);
            end
         end else if (wr_strobe) begin
            check("stray_wr_strobe", 1, 0);
         end
         if (protocol_err || cyc == perr_cyc) check("protocol_err", protocol_err, cyc == perr_cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NTOT; i++) mdl[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_sfrack", sfrack, 0);
      check("rst_sfrdatai", sfrdatai, 0);
      check("rst_wr_strobe", wr_strobe, 0);
      check("rst_wr_index", wr_index, 0);
      check("rst_protocol_err", protocol_err, 0);
      check_regs("rst_regs");
      rst = 1'b1;
      @(negedge clk);

      access(8'h83, 0, 1, 0, 8'hA5);
      check("byte3_after_write", reg_out[3*8 +: 8], 8'hA5);
      access(8'h83, 0, 0, 1, 8'h00);
      access(8'h83, 1, 0, 1, 8'h00);
      access(8'h90, 0, 1, 0, 8'h5A);
      access(8'h7F, 1, 0, 1, 8'h00);
      access(8'h8F, 1, 1, 0, 8'hC3);
      access(8'h80, 0, 1, 0, 8'h7E);
      access(8'h81, 0, 1, 0, 8'h11);
      access(8'h81, 0, 1, 1, 8'h55);
      check("both_no_change", reg_out[1*8 +: 8], 8'h11);
      access(8'h8F, 1, 0, 1, 8'h00);

`ifdef SFR_SLAVE_WP_EN
      access(8'h80, 1, 1, 0, 8'h01);
      access(8'h85, 0, 1, 0, 8'hFF);
      check("wp_blocked", reg_out[5*8 +: 8], 8'h00);
      access(8'h80, 1, 1, 0, 8'h00);
      access(8'h85, 0, 1, 0, 8'hFF);
      check("wp_released", reg_out[5*8 +: 8], 8'hFF);
`endif

      for (int n = 0; n < 60; n++) begin
         int a;
         int pg;
         int kind;
         a    = $urandom_range(8'h78, 8'h97);
         pg   = $urandom_range(0, 1);
         kind = $urandom_range(0, 9);
         if (kind == 0)      access(a, pg, 1, 1, 8'($urandom));
         else if (kind < 5)  access(a, pg, 1, 0, 8'($urandom));
         else                access(a, pg, 0, 1, 8'h00);
      end
      check_regs("regs_after_random");

      // Reset while a write is waiting: no ack, bank back to reset value
      @(negedge clk);
      sfraddr = 8'h84; sfr_page_sel = 1'b0; sfrdatao = 8'h3C; sfrwe = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_sfrack", sfrack, 0);
      sfrwe = 1'b0;
      for (int i = 0; i < NTOT; i++) mdl[i] = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_ack_queued", exp_q.size(), 0);
      check("abort_reg4", reg_out[4*8 +: 8], 8'h00);
      check_regs("abort_regs");
      access(8'h84, 0, 0, 1, 8'h00);
      access(8'h84, 0, 1, 0, 8'h3C);
      check("post_reset_write", reg_out[4*8 +: 8], 8'h3C);

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sfr_slave_regfile.md
Name: sfr_slave_regfile

Overview:
SFR bus responder, the target end of the SFR master interface. Decodes sfraddr and sfr_page_sel, services write (sfrwe) and read (sfroe) requests against a paged register bank, and returns sfrack and sfrdatai after a programmable number of wait states. Register contents are exported flat to the surrounding design. Used as a DUT-side target model in SFR benches and as a synthesizable generic register block.

Parameters:
ADDR_WIDTH, 8, width of sfraddr (matches SFR_ADDR_WIDTH)
DATA_WIDTH, 8, width of sfrdatao/sfrdatai (matches SFR_DATA_WIDTH)
PAGE_NUM, 2, number of register pages (matches SFR_PAGE_NUM, >=1)
REG_NUM, 16, registers per page
BASE_ADDR, 8'h80, first decoded address; hit when BASE_ADDR <= sfraddr < BASE_ADDR+REG_NUM
WAIT_STATES, 1, cycles between request capture and ack (0..15)
RESET_VALUE, 0, reset value of every register

Ports:
clk  in  1  bus clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
sfraddr  in  ADDR_WIDTH  access address
sfrwe  in  1  write request, held by master until ack
sfrdatao  in  DATA_WIDTH  write data from master
sfroe  in  1  read request, held by master until ack
sfr_page_sel  in  $clog2(PAGE_NUM) (min 1)  page select
sfrack  out  1  one-cycle access acknowledge
sfrdatai  out  DATA_WIDTH  read data to master, valid with sfrack
reg_out  out  PAGE_NUM*REG_NUM*DATA_WIDTH  all registers, page-major, reg 0 in LSBs
wr_strobe  out  1  one-cycle pulse on each committed write
wr_index  out  $clog2(PAGE_NUM*REG_NUM)  flat index of committed write, valid with wr_strobe
protocol_err  out  1  one-cycle pulse on illegal request

Behaviour:
- Reset (rst low, async): FSM to IDLE; sfrack=0, sfrdatai=0, wr_strobe=0, wr_index=0, protocol_err=0, all registers=RESET_VALUE. Reset mid-access aborts it with no register update and no ack.
- FSM states IDLE, WAIT, ACK, GAP.
- IDLE: on posedge with (sfrwe|sfroe) and address hit, capture addr, page, data, direction; go WAIT, or ACK if WAIT_STATES=0. Miss: stay IDLE, no response (other targets may own address).
- WAIT: counter counts WAIT_STATES cycles, then ACK. Request changes during WAIT are ignored (captured values used).
- ACK: sfrack=1 for exactly one cycle. Write: register updated in this cycle, wr_strobe=1, wr_index=page*REG_NUM+offset. Read: sfrdatai=register value, held until next ack or reset. Then GAP.
- GAP: one cycle, no capture (master deasserts request in this cycle). Then IDLE; a request still asserted in IDLE is a new access.
- Latency: request sampled at edge N -> sfrack high in cycle N+1+WAIT_STATES.
- sfrwe and sfroe both high on capture: protocol_err pulse at capture, access still acked on schedule, no register change, sfrdatai=0.
- sfr_page_sel >= PAGE_NUM on capture: treated as miss.
- Read data reflects any write committed in an earlier ack cycle (no bypass within the same cycle).
- Offset = sfraddr-BASE_ADDR, truncated to $clog2(REG_NUM) bits; no wrap, addresses past range miss.

Optional Feature:
SFR_SLAVE_WP_EN: register 0 of the last page is a lock register; while bit0=1, writes to every other register are acked but discarded (no wr_strobe); the lock register stays writable. Without the macro, every register is writable and register 0 of the last page is ordinary.

Test Plan:
- Write 8'hA5 to 8'h83 page 0, WAIT_STATES=1 -> sfrack 2 cycles after capture, reg_out byte 3=8'hA5, wr_strobe with wr_index=3.
- Read 8'h83 page 0 after above -> sfrack with sfrdatai=8'hA5; read 8'h83 page 1 -> 8'h00.
- Access 8'h90 (miss) and 8'h7F -> no sfrack within 20 cycles, reg_out unchanged.
- sfrwe=sfroe=1 at 8'h81 -> protocol_err one cycle, sfrack on schedule, sfrdatai=0, no register change.
- Assert rst low during WAIT of a write of 8'h3C -> no sfrack, register stays RESET_VALUE, FSM IDLE after release.
- With SFR_SLAVE_WP_EN: write 1 to 8'h80 page 1, then 8'hFF to 8'h85 page 0 -> acked, no wr_strobe, reg stays 0; write 0 to lock then retry -> reg=8'hFF.
